// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of instr_encoder.
// The master modport is the encoder side; the slave modport is the requester/imem side.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_class;
  logic [3:0]        req_cond;
  logic [5:0]        req_funct;
  logic [3:0]        req_rn;
  logic [3:0]        req_rd;
  logic [11:0]       req_src2;
  logic [23:0]       req_imm24;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  req_valid, req_class, req_cond, req_funct, req_rn, req_rd,
           req_src2, req_imm24, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output req_valid, req_class, req_cond, req_funct, req_rn, req_rd,
           req_src2, req_imm24, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming ARM instruction encoder: packs field requests into words, queues them, writes imem.
// Optional feature: define ENCODER_ILLEGAL_TRAP_EN to drop class-11 requests and flag err.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  instr_encoder_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              req_ready;
  logic              imem_we;
  logic              trap;
  logic              fire_req;
  logic              push;
  logic              pop;

  always_comb begin
    word = {bus.req_cond, bus.req_class, bus.req_funct, bus.req_rn, bus.req_rd, bus.req_src2};
    if (bus.req_class == 2'b10)
      word = {bus.req_cond, 2'b10, bus.req_funct[5:4], bus.req_imm24};
  end

`ifdef ENCODER_ILLEGAL_TRAP_EN
  assign trap = (bus.req_class == 2'b11);
`else
  assign trap = 1'b0;
`endif

  assign fire_req = bus.req_valid && req_ready;
  assign push     = fire_req && !trap;
  assign pop      = imem_we && bus.imem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DRAIN;
      DRAIN:   if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy is registered, so a freshly pushed word only becomes visible next cycle.
  always_comb begin
    req_ready = (state == RUN) && (count != FULL);
    imem_we   = (state != IDLE) && (count != '0);
    busy      = (state != IDLE);
  end

  assign bus.req_ready  = req_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = imem_we ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      word_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == DRAIN) && (state_next == IDLE);
      if (state == IDLE && start) begin
        addr       <= {base_addr[ADDR_W-1:2], 2'b00};
        word_count <= '0;
      end else if (pop) begin
        addr       <= addr + ADDR_W'(4);
        word_count <= word_count + 16'd1;
      end
    end
  end

`ifdef ENCODER_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (fire_req && trap)       err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized sessions against a queue model.
// The model tracks IDLE/RUN/DRAIN, the pending-word queue, next address, count and err.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
`ifdef ENCODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic        busy, done, err;
  logic [15:0] word_count;

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;

  int          mstate = 0;
  logic [31:0] mq[$];
  logic [31:0] maddr = 0;
  logic [15:0] mwc = 0;
  bit          merr = 0;
  bit          mdone = 0;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .finish(finish),
    .bus(bus), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode_ref(input req_t r);
    if (r.cls == 2'd2)
      return 32'(r.cond) * 32'h1000_0000 + 32'h0800_0000
           + (32'(r.funct) / 32'd16) * 32'h0100_0000 + 32'(r.imm24);
    return 32'(r.cond) * 32'h1000_0000 + 32'(r.cls) * 32'h0400_0000
         + 32'(r.funct) * 32'h0010_0000 + 32'(r.rn) * 32'h0001_0000
         + 32'(r.rd) * 32'h0000_1000 + 32'(r.src2);
  endfunction

  function automatic req_t mk(input logic [1:0] cls, input logic [3:0] cond, input logic [5:0] funct,
                              input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                              input logic [23:0] imm24);
    req_t r;
    r.cls = cls; r.cond = cond; r.funct = funct; r.rn = rn; r.rd = rd; r.src2 = src2; r.imm24 = imm24;
    return r;
  endfunction

  function automatic req_t rand_req(input bit legal_only);
    req_t r;
    r = req_t'({$urandom, $urandom});
    if (legal_only) r.cls = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic logic [31:0] log_addr(input int i);
    return (i < wlog_addr.size()) ? wlog_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (i < wlog_data.size()) ? wlog_data[i] : 32'hDEAD_BEEF;
  endfunction

  // imem_ready is owned by this process alone: 0 = stall, 1 = always ready, 2 = random.
  initial begin
    bus.imem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.imem_ready = 1'b0;
        1:       bus.imem_ready = 1'b1;
        default: bus.imem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Model: checks the current cycle, then advances to what the next rising edge will do.
  always @(negedge clk) begin
    int  pre;
    bit  wr;
    req_t r;
    if (!reset) begin
      mstate = 0; mq.delete(); maddr = 0; mwc = 0; merr = 0; mdone = 0;
    end
    checkOutput("req_ready", 64'(bus.req_ready), 64'(mstate == 1 && mq.size() < DEPTH));
    checkOutput("imem_we", 64'(bus.imem_we), 64'(mstate != 0 && mq.size() != 0));
    checkOutput("busy", 64'(busy), 64'(mstate != 0));
    checkOutput("done", 64'(done), 64'(mdone));
    checkOutput("err", 64'(err), 64'(merr));
    checkOutput("word_count", 64'(word_count), 64'(mwc));
    if (mstate != 0 && mq.size() != 0) begin
      checkOutput("imem_addr", 64'(bus.imem_addr), 64'(maddr));
      checkOutput("imem_wdata", 64'(bus.imem_wdata), 64'(mq[0]));
    end
    if (reset) begin
      pre   = mq.size();
      mdone = 0;
      wr    = (mstate != 0) && (pre != 0) && bus.imem_ready;
      if (wr) begin
        wlog_addr.push_back(maddr);
        wlog_data.push_back(mq.pop_front());
        maddr = maddr + 32'd4;
        mwc   = mwc + 16'd1;
      end
      if (mstate == 1 && pre < DEPTH && bus.req_valid) begin
        r = mk(bus.req_class, bus.req_cond, bus.req_funct, bus.req_rn, bus.req_rd,
               bus.req_src2, bus.req_imm24);
        if (TRAP && r.cls == 2'd3) merr = 1;
        else mq.push_back(encode_ref(r));
      end
      if (mstate == 0 && start) begin
        mstate = 1; maddr = base_addr & 32'hFFFF_FFFC; mwc = 0; merr = 0;
      end else if (mstate == 1 && finish) begin
        mstate = 2;
      end else if (mstate == 2 && pre == 0) begin
        mstate = 0; mdone = 1;
      end
    end
  end

  // All driving tasks begin and end 1 time unit after a rising edge.
  task automatic applyStimulus(input req_t r, input int budget, input bit with_finish, output bit ok);
    bus.req_class = r.cls; bus.req_cond = r.cond; bus.req_funct = r.funct;
    bus.req_rn = r.rn; bus.req_rd = r.rd; bus.req_src2 = r.src2; bus.req_imm24 = r.imm24;
    bus.req_valid = 1'b1;
    finish = with_finish;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
      if (ok) break;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input bit with_finish);
    base_addr = base; start = 1'b1; finish = with_finish;
    @(posedge clk); #1;
    start = 1'b0; finish = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    checkOutput({pfx, "_imem_we"}, 64'(bus.imem_we), 64'd0);
    checkOutput({pfx, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
    checkOutput({pfx, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
    checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
    checkOutput({pfx, "_done"}, 64'(done), 64'd0);
    checkOutput({pfx, "_err"}, 64'(err), 64'd0);
    checkOutput({pfx, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   ok;
    int   mark;
    int   n;
    int   exp_n;
    req_t r;
    req_t six[6];
    bus.req_valid = 1'b0; bus.req_class = 2'd0; bus.req_cond = 4'd0; bus.req_funct = 6'd0;
    bus.req_rn = 4'd0; bus.req_rd = 4'd0; bus.req_src2 = 12'd0; bus.req_imm24 = 24'd0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD R1,R2,#5 at 0x100
    mark = wlog_data.size();
    pulse_start(32'h100, 1'b0);
    applyStimulus(mk(2'd0, 4'hE, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0), 20, 1'b0, ok);
    checkOutput("add_accept", 64'(ok), 64'd1);
    pulse_finish();
    wait_done(50);
    checkOutput("add_writes", 64'(wlog_data.size() - mark), 64'd1);
    checkOutput("add_addr", 64'(log_addr(mark)), 64'h100);
    checkOutput("add_data", 64'(log_data(mark)), 64'hE282_1005);
    checkOutput("add_word_count", 64'(word_count), 64'd1);

    // LDR R3,[R4,#8] then BL
    mark = wlog_data.size();
    pulse_start(32'h400, 1'b0);
    applyStimulus(mk(2'd1, 4'hE, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0), 20, 1'b0, ok);
    applyStimulus(mk(2'd2, 4'hE, 6'b110101, 4'd7, 4'd9, 12'hABC, 24'h000010), 20, 1'b0, ok);
    pulse_finish();
    wait_done(50);
    checkOutput("ldr_data", 64'(log_data(mark)), 64'hE594_3008);
    checkOutput("ldr_addr", 64'(log_addr(mark)), 64'h400);
    checkOutput("bl_data", 64'(log_data(mark + 1)), 64'hEB00_0010);
    checkOutput("bl_addr", 64'(log_addr(mark + 1)), 64'h404);

    // FIFO fills while imem stalls; six words must still come out in order
    ready_mode = 0;
    @(posedge clk); #1;
    mark = wlog_data.size();
    pulse_start(32'h200, 1'b0);
    for (int i = 0; i < 6; i++) six[i] = rand_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(six[i], 10, 1'b0, ok);
      checkOutput("full_accept", 64'(ok), 64'd1);
    end
    applyStimulus(six[4], 4, 1'b0, ok);
    checkOutput("full_blocked", 64'(ok), 64'd0);
    checkOutput("full_ready_low", 64'(bus.req_ready), 64'd0);
    ready_mode = 1;
    for (int i = 4; i < 6; i++) begin
      applyStimulus(six[i], 20, 1'b0, ok);
      checkOutput("full_accept_late", 64'(ok), 64'd1);
    end
    pulse_finish();
    wait_done(50);
    checkOutput("full_writes", 64'(wlog_data.size() - mark), 64'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("full_order_data", 64'(log_data(mark + i)), 64'(encode_ref(six[i])));
      checkOutput("full_order_addr", 64'(log_addr(mark + i)), 64'(32'h200 + 32'(4 * i)));
    end

    // Illegal class between two legal requests
    mark = wlog_data.size();
    pulse_start(32'h300, 1'b0);
    applyStimulus(mk(2'd0, 4'h1, 6'd3, 4'd1, 4'd2, 12'h111, 24'h0), 20, 1'b0, ok);
    applyStimulus(mk(2'd3, 4'h2, 6'd5, 4'd3, 4'd4, 12'h222, 24'h0), 20, 1'b0, ok);
    checkOutput("illegal_consumed", 64'(ok), 64'd1);
    applyStimulus(mk(2'd1, 4'h3, 6'd7, 4'd5, 4'd6, 12'h333, 24'h0), 20, 1'b0, ok);
    pulse_finish();
    wait_done(50);
    checkOutput("illegal_writes", 64'(wlog_data.size() - mark), TRAP ? 64'd2 : 64'd3);
    checkOutput("illegal_err", 64'(err), 64'(TRAP));
    checkOutput("illegal_contig", 64'(log_addr(mark + 1)), 64'h304);

    // Address wrap and base alignment
    mark = wlog_data.size();
    pulse_start(32'hFFFF_FFFC, 1'b0);
    applyStimulus(rand_req(1'b1), 20, 1'b0, ok);
    applyStimulus(rand_req(1'b1), 20, 1'b0, ok);
    pulse_finish();
    wait_done(50);
    checkOutput("wrap_addr0", 64'(log_addr(mark)), 64'hFFFF_FFFC);
    checkOutput("wrap_addr1", 64'(log_addr(mark + 1)), 64'h0);
    mark = wlog_data.size();
    pulse_start(32'h103, 1'b0);
    applyStimulus(rand_req(1'b1), 20, 1'b0, ok);
    pulse_finish();
    wait_done(50);
    checkOutput("align_addr", 64'(log_addr(mark)), 64'h100);

    // start+finish together in IDLE, then finish alongside an accepted request
    mark = wlog_data.size();
    pulse_start(32'h500, 1'b1);
    checkOutput("sf_busy", 64'(busy), 64'd1);
    applyStimulus(rand_req(1'b1), 20, 1'b0, ok);
    applyStimulus(rand_req(1'b1), 20, 1'b1, ok);
    checkOutput("fin_accept", 64'(ok), 64'd1);
    wait_done(50);
    checkOutput("fin_writes", 64'(wlog_data.size() - mark), 64'd2);

    // Reset during DRAIN with three words queued
    ready_mode = 0;
    @(posedge clk); #1;
    pulse_start(32'h600, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(rand_req(1'b1), 10, 1'b0, ok);
    pulse_finish();
    checkOutput("drain_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;
    mark = wlog_data.size();
    pulse_start(32'h700, 1'b0);
    pulse_finish();
    wait_done(20);
    checkOutput("post_rst_writes", 64'(wlog_data.size() - mark), 64'd0);
    checkOutput("post_rst_count", 64'(word_count), 64'd0);

    // Randomized sessions with stalls, gaps and stray control pulses
    for (int s = 0; s < 10; s++) begin
      ready_mode = 2;
      if ($urandom_range(0, 1) == 1) pulse_finish();
      mark = wlog_data.size();
      pulse_start($urandom, 1'b0);
      n = $urandom_range(1, 10);
      exp_n = 0;
      for (int i = 0; i < n; i++) begin
        r = rand_req(1'b0);
        if (!(TRAP && r.cls == 2'd3)) exp_n++;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if ($urandom_range(0, 4) == 0) pulse_start($urandom, 1'b0);
        applyStimulus(r, 200, 1'b0, ok);
        checkOutput("rand_accept", 64'(ok), 64'd1);
      end
      pulse_finish();
      wait_done(400);
      checkOutput("rand_writes", 64'(wlog_data.size() - mark), 64'(exp_n));
      checkOutput("rand_word_count", 64'(word_count), 64'(exp_n));
    end

    ready_mode = 1;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
